// File: rtl/riscv_aes_seq_if.sv
// Signal bundle between the AES sequencer and its command, memory-read, AES-core and writeback peers.
// master = sequencer view, slave = surrounding-system view.
interface riscv_aes_seq_if;
  logic         start;
  logic [31:0]  src_addr;
  logic [31:0]  dst_addr;
  logic         busy;
  logic         done;
  logic         err;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic         aes_start;
  logic [127:0] aes_block;
  logic         aes_done;
  logic         wb_start;
  logic [31:0]  wb_addr;
  logic         wb_halt;

  modport master (
    input  start, src_addr, dst_addr, rd_valid, rd_data, aes_done, wb_halt,
    output busy, done, err, rd_req, rd_addr, aes_start, aes_block, wb_start, wb_addr
  );

  modport slave (
    output start, src_addr, dst_addr, rd_valid, rd_data, aes_done, wb_halt,
    input  busy, done, err, rd_req, rd_addr, aes_start, aes_block, wb_start, wb_addr
  );
endinterface

// File: rtl/riscv_aes_seq.sv
// AES job sequencer: fetch a 128-bit block as four word reads, run the AES core, launch writeback.
// Define AES_SEQ_IRQ_EN to add a sticky completion interrupt (irq / irq_clr).
module riscv_aes_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  riscv_aes_seq_if.master  bus
`ifdef AES_SEQ_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_clr
`endif
);

  localparam int unsigned WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_RUN_START,
    S_RUN,
    S_WB_START,
    S_WB_WAIT
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [31:0]    r_src, w_src_nxt;
  logic [31:0]    r_dst, w_dst_nxt;
  logic [1:0]     r_k, w_k_nxt;
  logic [127:0]   r_block, w_block_nxt;
  logic [WDW-1:0] r_wd, w_wd_nxt;
  logic           r_halt_seen, w_halt_seen_nxt;

  logic w_rd_req, w_aes_start, w_wb_start, w_done, w_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_k         <= '0;
      r_block     <= '0;
      r_wd        <= '0;
      r_halt_seen <= 1'b0;
    end else begin
      r_src       <= w_src_nxt;
      r_dst       <= w_dst_nxt;
      r_k         <= w_k_nxt;
      r_block     <= w_block_nxt;
      r_wd        <= w_wd_nxt;
      r_halt_seen <= w_halt_seen_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_src_nxt       = r_src;
    w_dst_nxt       = r_dst;
    w_k_nxt         = r_k;
    w_block_nxt     = r_block;
    w_wd_nxt        = r_wd;
    w_halt_seen_nxt = r_halt_seen;
    w_rd_req        = 1'b0;
    w_aes_start     = 1'b0;
    w_wb_start      = 1'b0;
    w_done          = 1'b0;
    w_err           = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_src_nxt   = bus.src_addr;
          w_dst_nxt   = bus.dst_addr;
          w_k_nxt     = '0;
          w_state_nxt = S_FETCH_REQ;
        end
      end
      S_FETCH_REQ: begin
        w_rd_req    = 1'b1;
        w_state_nxt = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (bus.rd_valid) begin
          // word 0 lands in the least significant lane, matching writeback order
          w_block_nxt[{r_k, 5'd0} +: 32] = bus.rd_data;
          if (r_k == 2'd3) begin
            w_state_nxt = S_RUN_START;
          end else begin
            w_k_nxt     = r_k + 2'd1;
            w_state_nxt = S_FETCH_REQ;
          end
        end
      end
      S_RUN_START: begin
        w_aes_start = 1'b1;
        w_wd_nxt    = '0;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // a result arriving on the timeout cycle still counts as success
        if (bus.aes_done) begin
          w_state_nxt = S_WB_START;
        end else if (r_wd == WD_LIMIT) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wd_nxt = r_wd + WDW'(1);
        end
      end
      S_WB_START: begin
        w_wb_start      = 1'b1;
        w_wd_nxt        = '0;
        w_halt_seen_nxt = 1'b0;
        w_state_nxt     = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        // halt must rise and then fall; the watchdog spans both phases
        if (r_halt_seen && !bus.wb_halt) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wd == WD_LIMIT) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wd_nxt = r_wd + WDW'(1);
          if (bus.wb_halt) begin
            w_halt_seen_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.busy      = (r_state != S_IDLE);
    bus.done      = w_done;
    bus.err       = w_err;
    bus.rd_req    = w_rd_req;
    bus.rd_addr   = r_src + {28'd0, r_k, 2'b00};
    bus.aes_start = w_aes_start;
    bus.aes_block = r_block;
    bus.wb_start  = w_wb_start;
    bus.wb_addr   = r_dst;
  end

`ifdef AES_SEQ_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else if (w_done || w_err) begin
      r_irq <= 1'b1;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_riscv_aes_seq.sv
// Directed self-checking bench for riscv_aes_seq with memory, AES-core and writeback models.
`timescale 1ns/1ps
module tb_riscv_aes_seq;

  logic clk;
  logic rst;

  riscv_aes_seq_if bus ();

`ifdef AES_SEQ_IRQ_EN
  logic irq;
  logic irq_clr;
`endif

  riscv_aes_seq #(.TIMEOUT(255)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef AES_SEQ_IRQ_EN
    ,
    .irq     (irq),
    .irq_clr (irq_clr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // stimulus controls, owned by the main process
  int          aes_lat;
  int          wb_hold;
  int          clr_at;
  int          epoch;
  logic [31:0] addr_lo, addr_hi;

  // cycle count and input models, owned by the driver
  int cyc;
  int rd_served, aes_served, wb_served;
  int aes_cnt, halt_cnt;

  // observations, owned by the monitor
  int           seen_epoch;
  int           rd_seen, aes_seen, wb_seen;
  int           n_rd, n_aes, n_wb, n_done, n_err, n_badaddr;
  int           t_aes, t_wb, t_done, t_err;
  logic [31:0]  rd_log [4];
  logic [31:0]  rd_pend_addr;
  logic [127:0] blk_at_aes;
  logic [31:0]  wb_addr_at;
  logic         busy_after_end;
  logic         prev_end;

  logic [31:0] mem [4];
  initial begin
    mem[0] = 32'h11111111;
    mem[1] = 32'h22222222;
    mem[2] = 32'h33333333;
    mem[3] = 32'h44444444;
  end

  // driver: update DUT inputs just after each rising edge
  initial begin
    cyc = 0; rd_served = 0; aes_served = 0; wb_served = 0; aes_cnt = 0; halt_cnt = 0;
    bus.rd_valid = 1'b0; bus.rd_data = '0; bus.aes_done = 1'b0; bus.wb_halt = 1'b0;
`ifdef AES_SEQ_IRQ_EN
    irq_clr = 1'b0;
`endif
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.rd_valid = 1'b0;
      if (rd_served != rd_seen) begin
        rd_served    = rd_seen;
        bus.rd_valid = 1'b1;
        bus.rd_data  = mem[rd_pend_addr[3:2]];
      end
      bus.aes_done = 1'b0;
      if (aes_served != aes_seen) begin
        aes_served = aes_seen;
        if (aes_lat > 0) aes_cnt = aes_lat;
      end
      if (aes_cnt > 0) begin
        aes_cnt--;
        if (aes_cnt == 0) bus.aes_done = 1'b1;
      end
      if (wb_served != wb_seen) begin
        wb_served = wb_seen;
        if (wb_hold > 0) halt_cnt = wb_hold;
      end else if (halt_cnt > 0) begin
        halt_cnt--;
      end
      bus.wb_halt = (halt_cnt > 0);
`ifdef AES_SEQ_IRQ_EN
      irq_clr = (cyc == clr_at);
`endif
    end
  end

  // monitor: sample DUT outputs on the falling edge
  initial begin
    seen_epoch = 0; rd_seen = 0; aes_seen = 0; wb_seen = 0; prev_end = 1'b0;
    n_rd = 0; n_aes = 0; n_wb = 0; n_done = 0; n_err = 0; n_badaddr = 0;
    t_aes = -1; t_wb = -1; t_done = -1; t_err = -1;
    busy_after_end = 1'bx; blk_at_aes = '0; wb_addr_at = '0; rd_pend_addr = '0;
    forever begin
      @(negedge clk);
      if (seen_epoch != epoch) begin
        seen_epoch = epoch;
        n_rd = 0; n_aes = 0; n_wb = 0; n_done = 0; n_err = 0; n_badaddr = 0;
        t_aes = -1; t_wb = -1; t_done = -1; t_err = -1;
        busy_after_end = 1'bx;
        for (int i = 0; i < 4; i++) rd_log[i] = '0;
      end
      if (prev_end) begin
        busy_after_end = bus.busy;
        prev_end       = 1'b0;
      end
      if (bus.rd_req) begin
        if (n_rd < 4) rd_log[n_rd] = bus.rd_addr;
        if (bus.rd_addr < addr_lo || bus.rd_addr > addr_hi) n_badaddr++;
        n_rd++;
        rd_pend_addr = bus.rd_addr;
        rd_seen++;
      end
      if (bus.aes_start) begin
        n_aes++; t_aes = cyc; blk_at_aes = bus.aes_block; aes_seen++;
      end
      if (bus.wb_start) begin
        n_wb++; t_wb = cyc; wb_addr_at = bus.wb_addr; wb_seen++;
      end
      if (bus.done) begin
        n_done++; t_done = cyc; prev_end = 1'b1;
      end
      if (bus.err) begin
        n_err++; t_err = cyc; prev_end = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_job(input logic [31:0] src, input logic [31:0] dst);
    tick(1);
    epoch++;
    bus.start    = 1'b1;
    bus.src_addr = src;
    bus.dst_addr = dst;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic finish_job(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_done + n_err > 0) break;
      tick(1);
    end
    check("job_ended", 1'((n_done + n_err) > 0), 1'b1);
    tick(3);
  endtask

  task automatic wait_aes(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_aes > 0) break;
      tick(1);
    end
    check("aes_started", 1'(n_aes > 0), 1'b1);
  endtask

  localparam logic [127:0] BLK = 128'h44444444_33333333_22222222_11111111;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
    aes_lat = 10; wb_hold = 20; clr_at = -1; epoch = 0;
    addr_lo = 32'h100; addr_hi = 32'h10C;
    tick(3);

    // reset state
    check("rst_busy",  bus.busy, 1'b0);
    check("rst_pulse", {bus.done, bus.err, bus.rd_req, bus.aes_start, bus.wb_start}, 5'b0);
    check("rst_block", bus.aes_block, 128'h0);
    check("rst_addr",  {bus.wb_addr, bus.rd_addr}, 64'h0);
    rst = 1'b0;

    // nominal job
    start_job(32'h100, 32'h200);
    finish_job(700);
    check("nom_rd0", rd_log[0], 32'h100);
    check("nom_rd1", rd_log[1], 32'h104);
    check("nom_rd2", rd_log[2], 32'h108);
    check("nom_rd3", rd_log[3], 32'h10C);
    check("nom_nrd", n_rd, 4);
    check("nom_block", blk_at_aes, BLK);
    check("nom_naes", n_aes, 1);
    check("nom_nwb", n_wb, 1);
    check("nom_wbaddr", wb_addr_at, 32'h200);
    check("nom_ndone", n_done, 1);
    check("nom_nerr", n_err, 0);
    check("nom_busy_after", busy_after_end, 1'b0);
    check("nom_aes_to_done", t_done - t_aes, 32);

    // AES never finishes
    aes_lat = 0;
    start_job(32'h100, 32'h200);
    finish_job(700);
    check("aesto_nerr", n_err, 1);
    check("aesto_timing", t_err - t_aes, 256);
    check("aesto_nwb", n_wb, 0);
    check("aesto_ndone", n_done, 0);
    check("aesto_busy_after", busy_after_end, 1'b0);

    // AES result on the very cycle the watchdog expires
    aes_lat = 256;
    start_job(32'h100, 32'h200);
    finish_job(900);
    check("edge_nerr", n_err, 0);
    check("edge_nwb", n_wb, 1);
    check("edge_ndone", n_done, 1);

    // writeback halt never rises
    aes_lat = 10; wb_hold = 0;
    start_job(32'h100, 32'h200);
    finish_job(700);
    check("wbto_nerr", n_err, 1);
    check("wbto_timing", t_err - t_wb, 256);
    check("wbto_ndone", n_done, 0);
    wb_hold = 20;

    // second start during fetch is ignored
    start_job(32'h100, 32'h200);
    tick(2);
    bus.start = 1'b1; bus.src_addr = 32'h300; bus.dst_addr = 32'h400;
    tick(1);
    bus.start = 1'b0;
    finish_job(700);
    check("sbusy_badaddr", n_badaddr, 0);
    check("sbusy_nrd", n_rd, 4);
    check("sbusy_ndone", n_done, 1);
    check("sbusy_wbaddr", wb_addr_at, 32'h200);

    // reset while in RUN
    aes_lat = 0;
    start_job(32'h100, 32'h200);
    wait_aes(100);
    tick(5);
    rst = 1'b1;
    tick(1);
    check("mrst_busy", bus.busy, 1'b0);
    check("mrst_pulse", {bus.done, bus.err, bus.rd_req, bus.aes_start, bus.wb_start}, 5'b0);
    check("mrst_block", bus.aes_block, 128'h0);
    check("mrst_wbaddr", bus.wb_addr, 32'h0);
`ifdef AES_SEQ_IRQ_EN
    check("mrst_irq", irq, 1'b0);
`endif
    rst = 1'b0;
    tick(300);
    check("mrst_nend", n_done + n_err, 0);
    aes_lat = 10;
    start_job(32'h100, 32'h200);
    finish_job(700);
    check("mrst_job_done", n_done, 1);
    check("mrst_job_block", blk_at_aes, BLK);

`ifdef AES_SEQ_IRQ_EN
    clr_at = cyc + 1;
    tick(2);
    check("irq_cleared", irq, 1'b0);
    start_job(32'h100, 32'h200);
    finish_job(700);
    check("irq_set_done", irq, 1'b1);
    tick(5);
    check("irq_sticky", irq, 1'b1);
    clr_at = cyc + 1;
    tick(2);
    check("irq_clr", irq, 1'b0);
    // clear coinciding with the error pulse
    aes_lat = 0;
    start_job(32'h100, 32'h200);
    wait_aes(100);
    clr_at = t_aes + 256;
    finish_job(700);
    check("irq_clr_on_err_cyc", t_err, clr_at);
    check("irq_set_wins", irq, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
